// File: rtl/rib_rr_arbiter_if.sv
// Request/grant bundle between the rib masters and the round-robin arbiter.
// The master modport drives requests and locks; the slave modport is the arbiter side.
interface rib_rr_arbiter_if;
   logic [3:0] req_i;
   logic [3:0] lock_i;
   logic [3:0] grant_o;
   logic [1:0] grant_id_o;
   logic       grant_vld_o;
   logic       hold_flag_o;

   modport master (
      output req_i,
      output lock_i,
      input  grant_o,
      input  grant_id_o,
      input  grant_vld_o,
      input  hold_flag_o
   );

   modport slave (
      input  req_i,
      input  lock_i,
      output grant_o,
      output grant_id_o,
      output grant_vld_o,
      output hold_flag_o
   );
endinterface

// File: rtl/rib_rr_arbiter.sv
// Four-master round-robin rib arbiter with bounded lock ownership.
// Define RIB_ARB_JTAG_PRIO_EN to give master 2 (JTAG) absolute, unbounded pre-emptive priority.
module rib_rr_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic           clk,
   input  logic           rst,
   rib_rr_arbiter_if.slave bus
);

   typedef enum logic {IDLE, OWN} state_t;

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

   state_t           state_reg, state_next;
   logic [3:0]       grant_reg, grant_next;
   logic [1:0]       id_reg, id_next;
   logic             vld_reg, vld_next;
   logic             hold_reg, hold_next;
   logic [1:0]       last_reg, last_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   logic [3:0] eligible;
   logic       others_req;
   logic       keep;
   logic       win_vld;
   logic [1:0] win_id;

   assign others_req = |(bus.req_i & ~grant_reg);

   // The current owner only competes when nobody else is asking.
   for (genvar gi = 0; gi < 4; gi++) begin : g_elig
      assign eligible[gi] = bus.req_i[gi] &&
                            !(state_reg == OWN && id_reg == 2'(gi) && others_req);
   end

   assign keep = (state_reg == OWN) && bus.req_i[id_reg] && bus.lock_i[id_reg] &&
                 (cnt_reg < HOLD_LIM);

   // Scan from last+4 down to last+1 so the closest requester after last ends up chosen.
   always_comb begin
      logic [1:0] idx;
      win_vld = 1'b0;
      win_id  = 2'd0;
      idx     = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         idx = last_reg + 2'(i) + 2'd1;
         if (eligible[idx]) begin
            win_vld = 1'b1;
            win_id  = idx;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      id_next    = id_reg;
      cnt_next   = cnt_reg;
      last_next  = last_reg;

`ifdef RIB_ARB_JTAG_PRIO_EN
      if (bus.req_i[2]) begin
         // JTAG grants leave last untouched so rotation among 0/1/3 is undisturbed.
         state_next = OWN;
         grant_next = 4'b0100;
         id_next    = 2'd2;
         cnt_next   = '0;
      end else
`endif
      begin
         case (state_reg)
            IDLE: begin
               if (win_vld) begin
                  state_next = OWN;
                  grant_next = 4'b0001 << win_id;
                  id_next    = win_id;
                  cnt_next   = '0;
                  last_next  = win_id;
               end
            end
            OWN: begin
               if (keep) begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end else if (win_vld) begin
                  grant_next = 4'b0001 << win_id;
                  id_next    = win_id;
                  cnt_next   = '0;
                  last_next  = win_id;
               end else begin
                  state_next = IDLE;
                  grant_next = 4'b0000;
                  id_next    = 2'd0;
                  cnt_next   = '0;
               end
            end
            default: begin
               state_next = IDLE;
               grant_next = 4'b0000;
               id_next    = 2'd0;
               cnt_next   = '0;
            end
         endcase
      end

      vld_next  = |grant_next;
      hold_next = grant_next[2] | grant_next[3];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         grant_reg <= 4'b0000;
         id_reg    <= 2'd0;
         vld_reg   <= 1'b0;
         hold_reg  <= 1'b0;
         last_reg  <= 2'd3;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         id_reg    <= id_next;
         vld_reg   <= vld_next;
         hold_reg  <= hold_next;
         last_reg  <= last_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign bus.grant_o     = grant_reg;
   assign bus.grant_id_o  = id_reg;
   assign bus.grant_vld_o = vld_reg;
   assign bus.hold_flag_o = hold_reg;

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Self-checking bench for rib_rr_arbiter: cycle model compared every cycle plus directed literals.
// Covers RIB_ARB_JTAG_PRIO_EN when the same macro is defined for the build.
module tb_rib_rr_arbiter;

   localparam int MAX_HOLD = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rib_rr_arbiter_if bus_if ();

   rib_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   // Model state: who owns the bus, how long it has held, and the last round-robin winner.
   bit m_vld   = 1'b0;
   int m_owner = 0;
   int m_held  = 0;
   int m_last  = 3;

   always @(posedge clk) begin
      int  w;
      int  nreq;
      bit  stay;
      logic [3:0] r;
      logic [3:0] l;
      r = bus_if.req_i;
      l = bus_if.lock_i;
      if (!rst) begin
         m_vld   <= 1'b0;
         m_owner <= 0;
         m_held  <= 0;
         m_last  <= 3;
      end else begin
         nreq = $countones(r);
         stay = m_vld && r[m_owner] && l[m_owner] && (m_held + 1 < MAX_HOLD);
`ifdef RIB_ARB_JTAG_PRIO_EN
         if (r[2]) begin
            m_vld   <= 1'b1;
            m_owner <= 2;
            m_held  <= 0;
         end else
`endif
         if (stay) begin
            m_held <= m_held + 1;
         end else begin
            w = -1;
            for (int i = 1; i <= 4; i++) begin
               int c;
               c = (m_last + i) % 4;
               if (w < 0 && r[c] && !(m_vld && c == m_owner && nreq > 1))
                  w = c;
            end
            if (w >= 0) begin
               m_vld   <= 1'b1;
               m_owner <= w;
               m_last  <= w;
            end else begin
               m_vld   <= 1'b0;
               m_owner <= 0;
            end
            m_held <= 0;
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] eg;
      logic [1:0] eid;
      bit         ehold;
      if (cmp_en) begin
         eg    = m_vld ? (4'b0001 << m_owner) : 4'b0000;
         eid   = m_vld ? 2'(m_owner) : 2'd0;
         ehold = m_vld && (m_owner >= 2);
         n_cmp++;
         if (bus_if.grant_o !== eg || bus_if.grant_id_o !== eid ||
             bus_if.grant_vld_o !== m_vld || bus_if.hold_flag_o !== ehold) begin
            n_fail++;
            $display("FAIL model t=%0t: grant=%b id=%0d vld=%b hold=%b, required grant=%b id=%0d vld=%b hold=%b",
                     $time, bus_if.grant_o, bus_if.grant_id_o, bus_if.grant_vld_o,
                     bus_if.hold_flag_o, eg, eid, m_vld, ehold);
         end
         n_cmp++;
         if (!$onehot0(bus_if.grant_o)) begin
            n_fail++;
            $display("FAIL onehot t=%0t: grant=%b, required one-hot or zero", $time, bus_if.grant_o);
         end
      end
   end

   task automatic tick(input logic [3:0] r, input logic [3:0] l);
      bus_if.req_i  = r;
      bus_if.lock_i = l;
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [3:0] eg, input bit ehold);
      logic [1:0] eid;
      eid = 2'd0;
      for (int i = 0; i < 4; i++) if (eg[i]) eid = 2'(i);
      n_cmp++;
      if (bus_if.grant_o !== eg || bus_if.hold_flag_o !== ehold ||
          bus_if.grant_id_o !== eid || bus_if.grant_vld_o !== (|eg)) begin
         n_fail++;
         $display("FAIL %s: grant=%b id=%0d vld=%b hold=%b, required grant=%b id=%0d vld=%b hold=%b",
                  name, bus_if.grant_o, bus_if.grant_id_o, bus_if.grant_vld_o,
                  bus_if.hold_flag_o, eg, eid, |eg, ehold);
      end else begin
         $display("ok   %s: grant=%b hold=%b", name, bus_if.grant_o, bus_if.hold_flag_o);
      end
   endtask

   initial begin
      bus_if.req_i  = 4'b0000;
      bus_if.lock_i = 4'b0000;
      rst = 1'b0;
      tick(4'b0000, 4'b0000);
      cmp_en = 1'b1;
      tick(4'b0000, 4'b0000);
      chk("reset", 4'b0000, 1'b0);
      rst = 1'b1;

`ifndef RIB_ARB_JTAG_PRIO_EN
      tick(4'b0001, 4'b0000);
      chk("first_grant_m0", 4'b0001, 1'b0);
      tick(4'b0000, 4'b0000);
      chk("release_idle", 4'b0000, 1'b0);

      // Fresh pointer: rotation starts at master 0.
      rst = 1'b0;
      tick(4'b0000, 4'b0000);
      rst = 1'b1;
      tick(4'b1111, 4'b0000); chk("rot0", 4'b0001, 1'b0);
      tick(4'b1111, 4'b0000); chk("rot1", 4'b0010, 1'b0);
      tick(4'b1111, 4'b0000); chk("rot2", 4'b0100, 1'b1);
      tick(4'b1111, 4'b0000); chk("rot3", 4'b1000, 1'b1);
      tick(4'b1111, 4'b0000); chk("rot4", 4'b0001, 1'b0);

      // Locked master 3 against master 1.
      rst = 1'b0;
      tick(4'b0000, 4'b0000);
      rst = 1'b1;
      tick(4'b1010, 4'b1000); chk("lock_m1_first", 4'b0010, 1'b0);
      for (int i = 0; i < MAX_HOLD; i++) begin
         tick(4'b1010, 4'b1000); chk($sformatf("lock_m3_hold%0d", i), 4'b1000, 1'b1);
      end
      tick(4'b1010, 4'b1000); chk("hold_expiry_m1", 4'b0010, 1'b0);
      tick(4'b1010, 4'b1000); chk("regrant_m3", 4'b1000, 1'b1);

      // Locked owner drops its request: immediate hand-over, counter restarts.
      tick(4'b0001, 4'b1000); chk("drop_to_m0", 4'b0001, 1'b0);
      tick(4'b1001, 4'b1000); chk("m3_again", 4'b1000, 1'b1);
      for (int i = 1; i < MAX_HOLD; i++) begin
         tick(4'b1001, 4'b1000); chk($sformatf("m3_fresh_hold%0d", i), 4'b1000, 1'b1);
      end
      tick(4'b1001, 4'b1000); chk("m3_expire_to_m0", 4'b0001, 1'b0);

      // Reset while master 3 owns the bus.
      tick(4'b1001, 4'b1000); chk("m3_before_rst", 4'b1000, 1'b1);
      rst = 1'b0;
      tick(4'b1001, 4'b1000); chk("rst_mid_own", 4'b0000, 1'b0);
      rst = 1'b1;
      tick(4'b1111, 4'b0000); chk("after_rst_m0", 4'b0001, 1'b0);

      // Sole locked requester keeps the bus across expiry.
      for (int i = 0; i < MAX_HOLD + 4; i++) begin
         tick(4'b1000, 4'b1000); chk($sformatf("sole_m3_%0d", i), 4'b1000, 1'b1);
      end
      tick(4'b0000, 4'b0000); chk("all_idle", 4'b0000, 1'b0);
`else
      tick(4'b0010, 4'b0010); chk("jtag_m1_owner", 4'b0010, 1'b0);
      tick(4'b0110, 4'b0010); chk("jtag_preempt", 4'b0100, 1'b1);
      for (int i = 0; i < MAX_HOLD + 4; i++) begin
         tick(4'b0100, 4'b0100); chk($sformatf("jtag_hold%0d", i), 4'b0100, 1'b1);
      end
      tick(4'b1011, 4'b0000); chk("jtag_resume_m3", 4'b1000, 1'b1);
      tick(4'b1011, 4'b0000); chk("jtag_resume_m0", 4'b0001, 1'b0);
      tick(4'b1011, 4'b0000); chk("jtag_resume_m1", 4'b0010, 1'b0);
      tick(4'b0000, 4'b0000); chk("jtag_idle", 4'b0000, 1'b0);
`endif

      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
